// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary helpers
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Width-parameterized Gray-to-binary converter built on the shared package helper.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/overflow logic of an asynchronous FIFO.
// Optional almost-full flag is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int AFULL_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wen,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              wr_overflow,
  output logic              almost_full
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (ADDR_W < 2 || AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_param
    $error("fifo_wptr_full: ADDR_W must be >= 2 and AFULL_THRESH within 0..DEPTH");
  end

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_q, wgray_d;
  logic [ADDR_W:0] full_gray;
  logic            wfull_q, wfull_d;
  logic            ovf_q, ovf_d;

  assign wen = winc & ~wfull_q;

  // Full when the next write pointer equals the read pointer with its two MSBs inverted.
  always_comb begin
    wbin_d    = wbin_q + {{ADDR_W{1'b0}}, wen};
    wgray_d   = (ADDR_W + 1)'(bin2gray(32'(wbin_d)));
    full_gray = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    wfull_d   = (wgray_d == full_gray);
    ovf_d     = winc & wfull_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(DEPTH - AFULL_THRESH);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] fill;
  logic            afull_q, afull_d;

  fifo_gray2bin #(
    .W(ADDR_W + 1)
  ) u_rptr_g2b (
    .gray_i(wq2_rptr),
    .bin_o (rbin)
  );

  // Modular subtraction stays correct across pointer wrap.
  always_comb begin
    fill    = wbin_d - rbin;
    afull_d = (fill >= AFULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign almost_full = afull_q;
`else
  assign almost_full = 1'b0;
`endif

  assign waddr       = wbin_q[ADDR_W-1:0];
  assign wptr        = wptr_q;
  assign wfull       = wfull_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a count-based model predicts each
// cycle's outputs, a monitor compares them one edge later.
module tb_fifo_wptr_full;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AFT    = 2;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       ovf;
    logic       afull;
    logic       wen;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [3:0] waddr;
  logic       wen;
  logic [4:0] wptr;
  logic       wfull;
  logic       wr_overflow;
  logic       almost_full;

  expect_t sbQueue[$];
  int checks = 0;
  int failures = 0;

  // Model state: unwrapped write/read counts plus the flags they imply.
  int   wTotal = 0;
  int   rTotal = 0;
  logic mFull = 1'b0;
  logic mOvf = 1'b0;
  logic mAfull = 1'b0;

  fifo_wptr_full #(
    .ADDR_W(ADDR_W),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .winc(winc),
    .wq2_rptr(wq2_rptr),
    .waddr(waddr),
    .wen(wen),
    .wptr(wptr),
    .wfull(wfull),
    .wr_overflow(wr_overflow),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] toGray(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic applyStimulus(input logic r, input logic w);
    expect_t e;
    int fill;
    @(negedge clk);
    if (r) rTotal = 0;
    rst = r;
    winc = w;
    wq2_rptr = toGray(rTotal);
    if (r) begin
      wTotal = 0;
      mFull  = 1'b0;
      mOvf   = 1'b0;
      mAfull = 1'b0;
    end else begin
      mOvf = w && mFull;
      if (w && !mFull) wTotal++;
      fill  = wTotal - rTotal;
      mFull = (fill == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
      mAfull = (fill >= DEPTH - AFT);
`else
      mAfull = 1'b0;
`endif
    end
    e.waddr = 4'(wTotal % DEPTH);
    e.wptr  = toGray(wTotal);
    e.wfull = mFull;
    e.ovf   = mOvf;
    e.afull = mAfull;
    e.wen   = w && !mFull;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge with a pending prediction is compared just after the edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput("waddr", {1'b0, waddr}, {1'b0, e.waddr});
        checkOutput("wptr", wptr, e.wptr);
        checkOutput("wfull", {4'b0, wfull}, {4'b0, e.wfull});
        checkOutput("wr_overflow", {4'b0, wr_overflow}, {4'b0, e.ovf});
        checkOutput("almost_full", {4'b0, almost_full}, {4'b0, e.afull});
        checkOutput("wen", {4'b0, wen}, {4'b0, e.wen});
      end
    end
  end

  initial begin
    // Reset held with writes requested.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    // Fill to full with the reader parked at zero, then overflow attempts.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    // One read releases full without any write, then one write refills.
    rTotal = 1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    // Wrap: reader trails the writer by three entries.
    for (int i = 0; i < 40; i++) begin
      rTotal = wTotal - 3;
      applyStimulus(1'b0, 1'b1);
    end
    // Mid-operation reset and the first write after it.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (rTotal < wTotal && $urandom_range(0, 2) == 0) rTotal++;
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbQueue.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", sbQueue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
